// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle load/store responder for the 8-bit core.
// Accepts one request at a time, commits it after LAT cycles against an
// internal memory, and returns loads as a one-cycle register-file
// write-back beat (data + destination register index).
module data_mem_ctrl #(
    parameter int W   = 8,
    parameter int A   = 8,
    parameter int R   = 4,
    parameter int LAT = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic         ReqWrite,
    input  logic [A-1:0] ReqAddr,
    input  logic [W-1:0] ReqData,
    input  logic [R-1:0] ReqRt,
    output logic         RspValid,
    output logic [W-1:0] RspData,
    output logic [R-1:0] RspRt,
    output logic         Stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // The counter holds LAT-1 at most; LAT is limited to 1..15.
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t         state_reg;
    logic [3:0]     cnt_reg;
    logic           write_reg;
    logic [A-1:0]   addr_reg;
    logic [W-1:0]   data_reg;
    logic [R-1:0]   rt_reg;
    logic           ready_reg;
    logic           rsp_valid_reg;
    logic [W-1:0]   rsp_data_reg;
    logic [R-1:0]   rsp_rt_reg;

    logic [W-1:0]   mem [0:(2**A)-1];

    logic           commit;
    logic           mem_write;

    // The access happens on the edge that ends the last WAIT cycle.
    assign commit    = (state_reg == WAIT) && (cnt_reg == 4'd0);
    // Reset on the commit edge must suppress the store, so gate it here
    // rather than relying on the FSM reset branch (memory itself is never reset).
    assign mem_write = commit && write_reg && !Reset;

    assign ReqReady = ready_reg;
    assign RspValid = rsp_valid_reg;
    assign RspData  = rsp_data_reg;
    assign RspRt    = rsp_rt_reg;
    assign Stall    = ReqValid & ~ready_reg;

    // Memory write port; contents survive Reset.
    always_ff @(posedge Clk) begin
        if (mem_write) begin
            mem[addr_reg] <= data_reg;
        end
    end

    // Request FSM with registered handshake and write-back outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            rt_reg        <= '0;
            ready_reg     <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_rt_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rsp_valid_reg <= 1'b0;
                    if (ReqValid) begin
                        write_reg <= ReqWrite;
                        addr_reg  <= ReqAddr;
                        data_reg  <= ReqData;
                        rt_reg    <= ReqRt;
                        cnt_reg   <= CNT_INIT;
                        ready_reg <= 1'b0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        if (write_reg) begin
                            // Store committed by the memory port this edge.
                            ready_reg <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            rsp_data_reg  <= mem[addr_reg];
                            rsp_rt_reg    <= rt_reg;
                            rsp_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    // Single write-back beat, then free for the next request.
                    rsp_valid_reg <= 1'b0;
                    ready_reg     <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    ready_reg     <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle data-memory responder for the 8-bit core. It accepts load/store requests from the datapath: the address comes from the register-file r0 output, and store data from a register operand. It performs the access against an internal W-bit memory after a fixed latency. For loads, it returns the result as a one-cycle write-back beat (data plus destination register index) that drives the register file's write enable, data-in and register address. The block sits between the decode/execute stage and the register-file write port, and raises Stall while a request cannot be accepted.

## Interface
Parameters:
- W, 8, data width
- A, 8, address width; memory depth is 2**A words
- R, 4, register-index width (matches the register file's address width)
- LAT, 2, access latency in cycles; legal range 1..15

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high reset
- ReqValid  in  1  core presents a request
- ReqReady  out  1  controller can accept a request this cycle
- ReqWrite  in  1  1 = store, 0 = load
- ReqAddr  in  A  memory address (register r0)
- ReqData  in  W  store data
- ReqRt  in  R  destination register for a load
- RspValid  out  1  one-cycle load write-back beat
- RspData  out  W  load result
- RspRt  out  R  destination register of the returned load
- Stall  out  1  combinational: ReqValid & ~ReqReady

## Operation
- States:
  - IDLE: ReqReady=1.
  - WAIT: ReqReady=0; a latency counter runs.
  - RESP: ReqReady=0; RspValid=1.
- Handshake: a request is accepted on the rising edge where ReqValid & ReqReady = 1.
  - On acceptance, ReqWrite, ReqAddr, ReqData and ReqRt are latched.
  - Request inputs are ignored in every other cycle.
  - The core may change or drop ReqValid freely while ReqReady=0.
- IDLE → WAIT on acceptance; the counter is loaded with LAT-1.
- WAIT: the counter decrements each cycle. When the counter is 0:
  - Store: mem[addr] ← data at that edge; next state IDLE.
  - Load: RspData ← mem[addr] and RspRt ← rt at that edge; next state RESP.
- RESP → IDLE unconditionally after one cycle.
- A store never produces RspValid.
- RspData and RspRt hold their last values until the next load response.
- Memory contents are not cleared by Reset; a memory word is undefined until it is first written.
- Read-after-write: a load accepted after a store has completed returns the stored value. Ordering is guaranteed because only one request is outstanding at a time.
- Address arithmetic: none. The full A-bit address is used, so every address 0..2**A-1 is valid, with no wrap or fault.
- Reset values: state=IDLE, counter=0, ReqReady=1, RspValid=0, RspData=0, RspRt=0.
- Reset mid-operation aborts the request:
  - No RspValid is produced.
  - A pending store whose commit edge has not yet occurred is discarded, leaving memory unchanged.
  - If Reset coincides with the commit edge, Reset wins and the write is suppressed.

## Timing
- Cycle 0 is the cycle with ReqValid & ReqReady high; acceptance happens at the end of cycle 0.
- Cycles 1..LAT: WAIT, ReqReady=0.
- Store: memory written at the end of cycle LAT; cycle LAT+1 is IDLE with ReqReady=1.
- Load: cycle LAT+1 is RESP with RspValid=1 and RspData/RspRt valid; cycle LAT+2 is IDLE.
- Throughput: one store per LAT+1 cycles; one load per LAT+2 cycles.
- Stall is purely combinational on ReqValid and the registered state; it has no cycle delay.
- Register-file write happens at the end of the RspValid cycle. The new value is visible on register-file outputs in cycle LAT+2.

## Test plan
- Reset: assert Reset for 2 cycles with ReqValid=1 → ReqReady=1, RspValid=0, RspData=0x00, RspRt=0, Stall=0 after release; no request is accepted during Reset.
- Store then load, LAT=2:
  - Store ReqAddr=0x10, ReqData=0xA5 → ReqReady low in cycles 1–2 and high in cycle 3; RspValid stays 0.
  - Then load 0x10 with ReqRt=5 → RspValid=1 exactly 3 cycles after acceptance, RspData=0xA5, RspRt=5, pulse width 1.
- Back-to-back: hold ReqValid=1 for loads to 0x00 then 0xFF (both preloaded) → Stall=1 throughout WAIT/RESP; second acceptance occurs in the first IDLE cycle; responses appear in order with the correct data and no lost beats.
- Address extremes: store 0x3C at 0xFF and 0xC3 at 0x00, then load both → 0x3C and 0xC3 respectively, with no aliasing.
- Reset mid-store: store 0x77 to 0x20 over an earlier 0x11; assert Reset in cycle LAT (the commit edge) → after release, loading 0x20 returns 0x11 and no spurious RspValid occurs.
- LAT=1 configuration: a load returns RspValid in cycle 2 and a store frees ReqReady in cycle 2; the data checks from the store-then-load scenario pass.
